// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the EX and MEM pipeline stages.
//   - PIPE_DATA_W / PIPE_RADDR_W : default datapath and register-address widths
//   - SHAMT_W                    : number of operand-A bits used as shift amount
//   - alu_op_e                   : 3-bit ALU opcode encoding
//   - ex_mem_t                   : EX/MEM bundle at default widths, for the
//                                  memory stage to consume as one value
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int PIPE_DATA_W  = 32;
    localparam int PIPE_RADDR_W = 5;
    localparam int SHAMT_W      = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SRA = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic                    valid;
        logic                    wreg;
        logic                    m2reg;
        logic                    wmem;
        logic                    ovf;
        logic [PIPE_DATA_W-1:0]  alu;
        logic [PIPE_DATA_W-1:0]  store;
        logic [PIPE_RADDR_W-1:0] rd;
    } ex_mem_t;

endpackage

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational ALU for the execute stage.
// Ports:
//   aluc   in  3       opcode (see pipe_pkg::alu_op_e)
//   a, b   in  DATA_W  operands; shifts move b by a[SHAMT_W-1:0]
//   result out DATA_W  result, wraps modulo 2^DATA_W
//   ovf    out 1       signed overflow for add/sub, 0 for every other op
// -----------------------------------------------------------------------------
module alu_core
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W
) (
    input  logic [2:0]        aluc,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              ovf
);

    localparam int MSB = DATA_W - 1;

    alu_op_e            op;
    logic [DATA_W-1:0]  sum;
    logic [DATA_W-1:0]  diff;
    logic [SHAMT_W-1:0] shamt;

    assign op    = alu_op_e'(aluc);
    assign sum   = a + b;
    assign diff  = a - b;
    assign shamt = a[SHAMT_W-1:0];

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch.
        result = '0;
        ovf    = 1'b0;
        case (op)
            ALU_ADD: begin
                result = sum;
                // Same-sign operands producing an opposite-sign sum.
                ovf    = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            ALU_SUB: begin
                result = diff;
                // Opposite-sign operands where the difference takes b's sign.
                ovf    = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLL: result = b << shamt;
            ALU_SRL: result = b >> shamt;
            ALU_SRA: result = $signed(b) >>> shamt;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/exe_mem_stage.sv
// -----------------------------------------------------------------------------
// exe_mem_stage
// Execute stage: operand selection, ALU, and the EX/MEM pipeline latch with a
// valid/ready handshake toward memory and a flush input from hazard control.
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   e_valid / e_ready                ID/EX handshake (e_ready = ~m_valid | m_ready)
//   e_wreg, e_m2reg, e_wmem          control bits from ID/EX
//   e_aluc, e_aluimm, e_shift        ALU opcode and operand-select controls
//   e_srca, e_srcb, e_imm, e_rd      operands, sign-extended immediate, dest reg
//   flush                            turn the instruction entering now into a bubble
//   m_ready / m_valid                EX/MEM handshake
//   m_wreg, m_m2reg, m_wmem, m_ovf   registered control and overflow
//   m_alu, m_store, m_rd             registered result, store data, dest reg
//   fwd_rd, fwd_wr, fwd_ld           combinational destination info for
//                                    forwarding / load-use detection
// -----------------------------------------------------------------------------
module exe_mem_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W  = PIPE_DATA_W,
    parameter int RADDR_W = PIPE_RADDR_W
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               e_valid,
    output logic               e_ready,
    input  logic               e_wreg,
    input  logic               e_m2reg,
    input  logic               e_wmem,
    input  logic [2:0]         e_aluc,
    input  logic               e_aluimm,
    input  logic               e_shift,
    input  logic [DATA_W-1:0]  e_srca,
    input  logic [DATA_W-1:0]  e_srcb,
    input  logic [DATA_W-1:0]  e_imm,
    input  logic [RADDR_W-1:0] e_rd,
    input  logic               flush,

    input  logic               m_ready,
    output logic               m_valid,
    output logic               m_wreg,
    output logic               m_m2reg,
    output logic               m_wmem,
    output logic [DATA_W-1:0]  m_alu,
    output logic [DATA_W-1:0]  m_store,
    output logic [RADDR_W-1:0] m_rd,
    output logic               m_ovf,

    output logic [RADDR_W-1:0] fwd_rd,
    output logic               fwd_wr,
    output logic               fwd_ld
);

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_ovf;
    logic              load;

    // Shift instructions take their amount from the shamt field of the
    // immediate (bits 10:6), zero-extended.
    assign op_a = e_shift  ? {{(DATA_W-SHAMT_W){1'b0}}, e_imm[10:6]} : e_srca;
    assign op_b = e_aluimm ? e_imm : e_srcb;

    alu_core #(
        .DATA_W (DATA_W)
    ) u_alu (
        .aluc   (e_aluc),
        .a      (op_a),
        .b      (op_b),
        .result (alu_result),
        .ovf    (alu_ovf)
    );

    // The latch can take a new bundle when empty or when its current bundle
    // leaves on this same edge, giving one instruction per cycle.
    assign e_ready = ~m_valid | m_ready;
    assign load    = e_ready & e_valid & ~flush;

    // Forwarding info reflects the instruction sitting in ID/EX regardless of
    // flush; hazard logic decides for itself what a flushed slot means.
    assign fwd_rd = e_rd;
    assign fwd_wr = e_valid & e_wreg & ~e_m2reg;
    assign fwd_ld = e_valid & e_m2reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: data fields are reset too because they are directly
            // visible outputs; a defined value avoids X leaking downstream.
            m_valid <= 1'b0;
            m_wreg  <= 1'b0;
            m_m2reg <= 1'b0;
            m_wmem  <= 1'b0;
            m_ovf   <= 1'b0;
            m_alu   <= '0;
            m_store <= '0;
            m_rd    <= '0;
        end else if (e_ready) begin
            if (load) begin
                // NOTE: non-blocking so every register samples pre-edge values.
                m_valid <= 1'b1;
                m_wreg  <= e_wreg;
                m_m2reg <= e_m2reg;
                m_wmem  <= e_wmem;
                m_ovf   <= alu_ovf;
                m_alu   <= alu_result;
                m_store <= e_srcb;
                m_rd    <= e_rd;
            end else begin
                // Bubble: clear everything with a downstream side effect;
                // data fields are left as they were.
                m_valid <= 1'b0;
                m_wreg  <= 1'b0;
                m_m2reg <= 1'b0;
                m_wmem  <= 1'b0;
                m_ovf   <= 1'b0;
            end
        end
        // else: memory is stalled on a live bundle, everything holds.
    end

endmodule

// File: tb/tb_exe_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_exe_mem_stage
// Self-checking bench for exe_mem_stage: directed scenarios plus a randomized
// run compared against a cycle-level behavioural model of the stage.
// -----------------------------------------------------------------------------
module tb_exe_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        e_valid, e_wreg, e_m2reg, e_wmem, e_aluimm, e_shift, flush, m_ready;
    logic [2:0]  e_aluc;
    logic [31:0] e_srca, e_srcb, e_imm;
    logic [4:0]  e_rd;

    logic        e_ready, m_valid, m_wreg, m_m2reg, m_wmem, m_ovf, fwd_wr, fwd_ld;
    logic [31:0] m_alu, m_store;
    logic [4:0]  m_rd, fwd_rd;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit        valid, wreg, m2reg, wmem, ovf;
        bit [31:0] alu, store;
        bit [4:0]  rd;
    } mdl_t;

    mdl_t mdl;

    exe_mem_stage dut (
        .clk      (clk),
        .rst      (rst),
        .e_valid  (e_valid),
        .e_ready  (e_ready),
        .e_wreg   (e_wreg),
        .e_m2reg  (e_m2reg),
        .e_wmem   (e_wmem),
        .e_aluc   (e_aluc),
        .e_aluimm (e_aluimm),
        .e_shift  (e_shift),
        .e_srca   (e_srca),
        .e_srcb   (e_srcb),
        .e_imm    (e_imm),
        .e_rd     (e_rd),
        .flush    (flush),
        .m_ready  (m_ready),
        .m_valid  (m_valid),
        .m_wreg   (m_wreg),
        .m_m2reg  (m_m2reg),
        .m_wmem   (m_wmem),
        .m_alu    (m_alu),
        .m_store  (m_store),
        .m_rd     (m_rd),
        .m_ovf    (m_ovf),
        .fwd_rd   (fwd_rd),
        .fwd_wr   (fwd_wr),
        .fwd_ld   (fwd_ld)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Behavioural prediction of the bundle the current inputs would load,
    // using wide signed arithmetic for the overflow decision.
    function automatic mdl_t predict();
        mdl_t   r;
        bit [31:0] a, b;
        longint sa, sb, wide;
        int     amt;
        a   = e_shift ? ((e_imm >> 6) & 32'h1F) : e_srca;
        b   = e_aluimm ? e_imm : e_srcb;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        amt = int'(a % 32);
        r.ovf = 1'b0;
        case (e_aluc)
            3'd0: begin wide = sa + sb; r.alu = wide[31:0];
                        r.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
            3'd1: begin wide = sa - sb; r.alu = wide[31:0];
                        r.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
            3'd2: r.alu = a & b;
            3'd3: r.alu = a | b;
            3'd4: r.alu = a ^ b;
            3'd5: r.alu = b << amt;
            3'd6: r.alu = b >> amt;
            default: begin wide = sb >>> amt; r.alu = wide[31:0]; end
        endcase
        r.valid = 1'b1;
        r.wreg  = e_wreg;
        r.m2reg = e_m2reg;
        r.wmem  = e_wmem;
        r.store = e_srcb;
        r.rd    = e_rd;
        return r;
    endfunction

    // Advance the model by one edge under the current inputs, then wait for
    // the edge and settle 1 time unit past it.
    task automatic tick();
        if (rst) begin
            if (!mdl.valid || m_ready) begin
                if (e_valid && !flush) begin
                    mdl = predict();
                end else begin
                    mdl.valid = 1'b0; mdl.wreg = 1'b0; mdl.m2reg = 1'b0;
                    mdl.wmem  = 1'b0; mdl.ovf  = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        mdl = '{valid: 1'b0, wreg: 1'b0, m2reg: 1'b0, wmem: 1'b0, ovf: 1'b0,
                alu: 32'd0, store: 32'd0, rd: 5'd0};
    endtask

    task automatic set_instr(input bit [2:0] aluc, input bit [31:0] a, input bit [31:0] b,
                             input bit [31:0] imm, input bit [4:0] rd);
        e_valid = 1'b1; flush = 1'b0;
        e_wreg = 1'b1; e_m2reg = 1'b0; e_wmem = 1'b0;
        e_aluimm = 1'b0; e_shift = 1'b0;
        e_aluc = aluc; e_srca = a; e_srcb = b; e_imm = imm; e_rd = rd;
    endtask

    task automatic idle();
        e_valid = 1'b0; flush = 1'b0;
        e_wreg = 1'b0; e_m2reg = 1'b0; e_wmem = 1'b0;
        e_aluimm = 1'b0; e_shift = 1'b0; e_aluc = 3'd0;
        e_srca = '0; e_srcb = '0; e_imm = '0; e_rd = '0;
    endtask

    task automatic test_reset();
        idle();
        m_ready = 1'b1;
        rst = 1'b0;
        #1;
        checks++;
        if ({m_valid, m_wreg, m_m2reg, m_wmem, m_ovf, m_alu, m_store, m_rd} !== '0) begin
            failures++;
            $display("FAIL reset_state: got v=%b w=%b l=%b s=%b o=%b alu=%h st=%h rd=%h, want all 0",
                     m_valid, m_wreg, m_m2reg, m_wmem, m_ovf, m_alu, m_store, m_rd);
        end
        checks++;
        if (e_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_e_ready: got %b want 1", e_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_model();
    endtask

    task automatic test_add_ovf();
        set_instr(3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0, 5'd3);
        m_ready = 1'b1;
        tick();
        checks++;
        if (m_alu !== 32'h8000_0000 || m_ovf !== 1'b1 || m_valid !== 1'b1 || m_rd !== 5'd3) begin
            failures++;
            $display("FAIL add_ovf: got alu=%h ovf=%b v=%b rd=%0d want 80000000/1/1/3",
                     m_alu, m_ovf, m_valid, m_rd);
        end
        // sub overflow: 0x80000000 - 1
        set_instr(3'b001, 32'h8000_0000, 32'h0000_0001, 32'h0, 5'd4);
        tick();
        checks++;
        if (m_alu !== 32'h7FFF_FFFF || m_ovf !== 1'b1) begin
            failures++;
            $display("FAIL sub_ovf: got alu=%h ovf=%b want 7fffffff/1", m_alu, m_ovf);
        end
        // wrap without overflow: -1 + 1
        set_instr(3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 5'd5);
        tick();
        checks++;
        if (m_alu !== 32'h0 || m_ovf !== 1'b0) begin
            failures++;
            $display("FAIL add_wrap: got alu=%h ovf=%b want 00000000/0", m_alu, m_ovf);
        end
    endtask

    task automatic test_shift_imm();
        set_instr(3'b111, 32'hDEAD_BEEF, 32'hF000_0000, 32'h0000_0100, 5'd6);
        e_shift = 1'b1;
        m_ready = 1'b1;
        tick();
        checks++;
        if (m_alu !== 32'hFF00_0000 || m_ovf !== 1'b0) begin
            failures++;
            $display("FAIL sra_shamt: got alu=%h ovf=%b want ff000000/0", m_alu, m_ovf);
        end
        // srl by the same amount must not sign-extend
        set_instr(3'b110, 32'hDEAD_BEEF, 32'hF000_0000, 32'h0000_0100, 5'd6);
        e_shift = 1'b1;
        tick();
        checks++;
        if (m_alu !== 32'h0F00_0000) begin
            failures++;
            $display("FAIL srl_shamt: got alu=%h want 0f000000", m_alu);
        end
        // sll uses only A[4:0]: srca=0x23 shifts by 3
        set_instr(3'b101, 32'h0000_0023, 32'h0000_0001, 32'h0, 5'd7);
        tick();
        checks++;
        if (m_alu !== 32'h0000_0008) begin
            failures++;
            $display("FAIL sll_amt5: got alu=%h want 00000008", m_alu);
        end
    endtask

    task automatic test_imm_or();
        set_instr(3'b011, 32'h0000_00F0, 32'h1234_5678, 32'hFFFF_000F, 5'd9);
        e_aluimm = 1'b1;
        m_ready = 1'b1;
        tick();
        checks++;
        if (m_alu !== 32'hFFFF_00FF || m_store !== 32'h1234_5678 || m_ovf !== 1'b0) begin
            failures++;
            $display("FAIL imm_or: got alu=%h store=%h ovf=%b want ffff00ff/12345678/0",
                     m_alu, m_store, m_ovf);
        end
    endtask

    task automatic test_backpressure();
        m_ready = 1'b1;
        set_instr(3'b000, 32'd1, 32'd2, 32'h0, 5'd1);   // A
        tick();
        set_instr(3'b000, 32'd10, 32'd20, 32'h0, 5'd2); // B
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (e_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_e_ready[%0d]: got %b want 0", i, e_ready);
            end
            tick();
            checks++;
            if (m_valid !== 1'b1 || m_alu !== 32'd3 || m_rd !== 5'd1) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got v=%b alu=%0d rd=%0d want 1/3/1",
                         i, m_valid, m_alu, m_rd);
            end
        end
        // flush while stalled must not disturb the held bundle
        flush = 1'b1;
        tick();
        checks++;
        if (m_valid !== 1'b1 || m_alu !== 32'd3 || m_wreg !== 1'b1) begin
            failures++;
            $display("FAIL bp_flush_hold: got v=%b alu=%0d w=%b want 1/3/1", m_valid, m_alu, m_wreg);
        end
        flush = 1'b0;
        m_ready = 1'b1;
        #1;
        checks++;
        if (e_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_ready: got %b want 1", e_ready);
        end
        tick();
        checks++;
        if (m_valid !== 1'b1 || m_alu !== 32'd30 || m_rd !== 5'd2) begin
            failures++;
            $display("FAIL bp_release: got v=%b alu=%0d rd=%0d want 1/30/2", m_valid, m_alu, m_rd);
        end
        idle();
        tick();
        checks++;
        if (m_valid !== 1'b0 || m_wreg !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain: got v=%b w=%b want 0/0", m_valid, m_wreg);
        end
    endtask

    task automatic test_flush();
        set_instr(3'b000, 32'd5, 32'd6, 32'h0, 5'd12);
        e_wmem = 1'b1;
        flush = 1'b1;
        m_ready = 1'b1;
        #1;
        checks++;
        if (fwd_wr !== 1'b1 || fwd_rd !== 5'd12 || fwd_ld !== 1'b0) begin
            failures++;
            $display("FAIL flush_fwd: got wr=%b rd=%0d ld=%b want 1/12/0", fwd_wr, fwd_rd, fwd_ld);
        end
        tick();
        checks++;
        if (m_valid !== 1'b0 || m_wreg !== 1'b0 || m_wmem !== 1'b0) begin
            failures++;
            $display("FAIL flush_bubble: got v=%b w=%b s=%b want 0/0/0", m_valid, m_wreg, m_wmem);
        end
        // load instruction: forwardable-now must be 0, load-use flag 1
        e_m2reg = 1'b1;
        #1;
        checks++;
        if (fwd_wr !== 1'b0 || fwd_ld !== 1'b1) begin
            failures++;
            $display("FAIL fwd_load: got wr=%b ld=%b want 0/1", fwd_wr, fwd_ld);
        end
        idle();
        tick();
    endtask

    task automatic test_back_to_back();
        bit [31:0] want;
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_instr(3'b000, 32'(i * 100), 32'(i + 7), 32'h0, 5'(i + 20));
            #1;
            checks++;
            if (e_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready[%0d]: got %b want 1", i, e_ready);
            end
            tick();
            want = 32'(i * 101 + 7);
            checks++;
            if (m_valid !== 1'b1 || m_alu !== want || m_rd !== 5'(i + 20)) begin
                failures++;
                $display("FAIL b2b[%0d]: got v=%b alu=%0d rd=%0d want 1/%0d/%0d",
                         i, m_valid, m_alu, m_rd, want, i + 20);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            e_valid  = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 7) == 0);
            m_ready  = ($urandom_range(0, 2) != 0);
            e_wreg   = 1'($urandom);
            e_m2reg  = 1'($urandom);
            e_wmem   = 1'($urandom);
            e_aluc   = 3'($urandom);
            e_aluimm = 1'($urandom);
            e_shift  = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       e_srca = 32'h7FFF_FFFF;
                1:       e_srca = 32'h8000_0000;
                default: e_srca = $urandom;
            endcase
            e_srcb = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            e_imm  = $urandom;
            e_rd   = 5'($urandom);
            #1;
            checks++;
            if (e_ready !== (!mdl.valid || m_ready) || fwd_rd !== e_rd ||
                fwd_wr !== (e_valid && e_wreg && !e_m2reg) || fwd_ld !== (e_valid && e_m2reg)) begin
                failures++;
                $display("FAIL rnd_comb[%0d]: got rdy=%b fwd=%0d/%b/%b", n, e_ready, fwd_rd, fwd_wr, fwd_ld);
            end
            tick();
            checks++;
            if (m_valid !== mdl.valid || m_wreg !== mdl.wreg || m_m2reg !== mdl.m2reg ||
                m_wmem !== mdl.wmem) begin
                failures++;
                $display("FAIL rnd_ctrl[%0d]: got v=%b w=%b l=%b s=%b want %b/%b/%b/%b", n,
                         m_valid, m_wreg, m_m2reg, m_wmem, mdl.valid, mdl.wreg, mdl.m2reg, mdl.wmem);
            end
            if (mdl.valid) begin
                checks++;
                if (m_alu !== mdl.alu || m_ovf !== mdl.ovf || m_store !== mdl.store || m_rd !== mdl.rd) begin
                    failures++;
                    $display("FAIL rnd_data[%0d]: got alu=%h ovf=%b st=%h rd=%0d want %h/%b/%h/%0d", n,
                             m_alu, m_ovf, m_store, m_rd, mdl.alu, mdl.ovf, mdl.store, mdl.rd);
                end
            end
        end
        idle();
        m_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b0;
        set_instr(3'b100, 32'hAAAA_0000, 32'h0000_5555, 32'h0, 5'd17);
        e_wmem = 1'b1;
        tick();
        checks++;
        if (m_valid !== 1'b1 || m_alu !== 32'hAAAA_5555) begin
            failures++;
            $display("FAIL mid_load: got v=%b alu=%h want 1/aaaa5555", m_valid, m_alu);
        end
        #2;
        rst = 1'b0;
        #1;
        clear_model();
        checks++;
        if ({m_valid, m_wreg, m_m2reg, m_wmem, m_ovf, m_alu, m_store, m_rd} !== '0) begin
            failures++;
            $display("FAIL mid_reset_async: got v=%b w=%b alu=%h st=%h rd=%0d want all 0",
                     m_valid, m_wreg, m_alu, m_store, m_rd);
        end
        #1;
        rst = 1'b1;
        m_ready = 1'b1;
        set_instr(3'b010, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0, 5'd30);
        tick();
        checks++;
        if (m_valid !== 1'b1 || m_alu !== 32'h0F00_0F00 || m_rd !== 5'd30 || m_store !== 32'h0FF0_0FF0) begin
            failures++;
            $display("FAIL post_reset_load: got v=%b alu=%h rd=%0d st=%h want 1/0f000f00/30/0ff00ff0",
                     m_valid, m_alu, m_rd, m_store);
        end
        idle();
        tick();
    endtask

    initial begin
        clear_model();
        test_reset();
        test_add_ovf();
        test_shift_imm();
        test_imm_or();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exe_mem_stage.md
Name: exe_mem_stage

Overview:
- Consumer end of the ID/EX pipeline latch.
- Takes the registered decode bundle (control bits EWREG/EM2REG/EWMEM/EALUC/EALUIMM/ESHIFT, operands, sign-extended immediate, destination register address) and performs operand selection and the ALU operation.
- Captures the result into the EX/MEM latch, with a valid/ready handshake toward the memory stage and a flush input from hazard control.
- Also exports combinational destination info for forwarding and hazard detection.

Parameters:
- DATA_W, 32, operand/result width.
- RADDR_W, 5, register-file address width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- e_valid  in  1  ID/EX latch holds a live instruction.
- e_ready  out  1  stage can accept the ID/EX bundle this cycle.
- e_wreg, e_m2reg, e_wmem  in  1 each  control bits from ID/EX.
- e_aluc  in  3  ALU opcode.
- e_aluimm  in  1  operand B = e_imm.
- e_shift  in  1  operand A = zero-extended e_imm[10:6] (shamt).
- e_srca, e_srcb  in  DATA_W  register operands.
- e_imm  in  DATA_W  sign-extended immediate.
- e_rd  in  RADDR_W  destination register.
- flush  in  1  kill the instruction entering this cycle.
- m_ready  in  1  memory stage accepts the EX/MEM bundle.
- m_valid  out  1  EX/MEM latch holds a live instruction.
- m_wreg, m_m2reg, m_wmem  out  1 each  registered control.
- m_alu  out  DATA_W  registered ALU result.
- m_store  out  DATA_W  registered e_srcb (store data).
- m_rd  out  RADDR_W  registered destination.
- m_ovf  out  1  registered signed overflow of add/sub.
- fwd_rd  out  RADDR_W  combinational e_rd.
- fwd_wr  out  1  combinational e_valid & e_wreg & ~e_m2reg (result forwardable now).
- fwd_ld  out  1  combinational e_valid & e_m2reg (load-use hazard source).

Behaviour:
- Reset (rst=0, async): m_valid, m_wreg, m_m2reg, m_wmem, m_ovf = 0; m_alu, m_store = 0; m_rd = 0.
- Operand A = e_shift ? {27'b0, e_imm[10:6]} : e_srca.
- Operand B = e_aluimm ? e_imm : e_srcb.
- ALU opcodes (e_aluc):
  - 000 add.
  - 001 sub (A-B).
  - 010 and.
  - 011 or.
  - 100 xor.
  - 101 sll (B << A[4:0]).
  - 110 srl (B >> A[4:0]).
  - 111 sra (arithmetic B >> A[4:0]).
- Shift amounts use only A[4:0].
- Overflow: for add/sub only, signed overflow of the DATA_W result; 0 for all other ops.
- Results wrap modulo 2^DATA_W; no trap is taken here.
- e_ready = ~m_valid | m_ready (combinational).
- Load condition: e_ready & e_valid & ~flush. On the clock edge:
  - m_valid <= 1.
  - All m_* fields <= computed values.
  - Latency is exactly 1 cycle.
- Drain: e_ready & ~(e_valid & ~flush) -> m_valid <= 0.
  - m_wreg, m_m2reg, m_wmem <= 0 (bubble; no side effects downstream).
  - Data fields may hold.
- Hold: m_valid & ~m_ready -> every output register keeps its value, regardless of e_valid or flush. The upstream stall is via e_ready=0.
- flush with e_ready=1 always produces a bubble, even if e_valid=1.
- Simultaneous m_ready=1 and a new load: the old bundle is consumed and the new one is loaded on the same edge, giving back-to-back throughput of 1/cycle.
- Reset asserted mid-operation: the in-flight instruction is discarded and all outputs go to reset values immediately.
- fwd_* signals are purely combinational from the e_* inputs and ignore flush.

Decomposition:
- Shared package pipe_pkg:
  - ALU opcode constants (ALU_ADD..ALU_SRA).
  - DATA_W/RADDR_W defaults.
  - The EX/MEM bundle struct for reuse by the memory stage.
- One sub-module, alu_core: combinational A/B/op -> result, ovf.
- The latch, handshake and operand muxing stay in exe_mem_stage.

Test Plan:
- Reset: drive rst=0 mid-traffic with m_valid=1 -> all m_* go to 0 without waiting for clk; after release, first load appears 1 cycle later.
- ALU and overflow: e_aluc=000, srca=0x7FFFFFFF, srcb=1, e_valid=1, m_ready=1 -> next cycle m_alu=0x80000000, m_ovf=1, m_valid=1.
- Shift and immediate: e_aluc=111, e_shift=1, e_imm=0x00000100 (shamt 4), srcb=0xF0000000 -> m_alu=0xFF000000, m_ovf=0.
- Immediate OR with store data: e_aluimm=1, e_aluc=011, srca=0x00F0, imm=0xFFFF000F -> m_alu=0xFFFF00FF, m_store=srcb unchanged.
- Backpressure: load instr A, then hold m_ready=0 for 3 cycles while offering B -> e_ready=0, m_* stay A; raise m_ready -> B loaded next edge, A consumed.
- Flush: e_valid=1, e_wreg=1, e_wmem=1, flush=1, m_ready=1 -> m_valid=0, m_wreg=0, m_wmem=0; fwd_wr=1 during that cycle.
